// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator back-end.
// The result FSM state type and default geometry live here so that the
// accumulator and the argmax stage agree on them.
package accum_pkg;

  // Default number of classification labels and accumulator width.
  localparam int ACC_N_LABELS   = 4;
  localparam int ACC_FIFO_WIDTH = 16;

  // Result FSM: wait for an update, scan labels, then present the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/accum_argmax_if.sv
// Bundle of the accum_argmax data/handshake signals.
// Result handshake: o_res_vld is raised by the block and holds, together with
// o_res_is_clf/o_res_label/o_res_value, until a cycle in which i_res_rdy is
// also high; that cycle is the single transfer. The upstream *_vld inputs are
// one-cycle update pulses with no back-pressure: any pulse the block cannot
// take is dropped and reported on o_overrun one cycle later.
interface accum_argmax_if #(
  parameter int N_LABELS   = accum_pkg::ACC_N_LABELS,
  parameter int FIFO_WIDTH = accum_pkg::ACC_FIFO_WIDTH,
  localparam int LBL_W     = $clog2(N_LABELS)
);

  logic                           i_flush;
  logic [N_LABELS*FIFO_WIDTH-1:0] i_clf_accum_reg;
  logic [N_LABELS-1:0]            i_clf_accum_reg_vld;
  logic [FIFO_WIDTH-1:0]          i_rgs_accum_reg;
  logic                           i_rgs_accum_reg_vld;
  logic                           o_res_vld;
  logic                           i_res_rdy;
  logic                           o_res_is_clf;
  logic [LBL_W-1:0]               o_res_label;
  logic [FIFO_WIDTH-1:0]          o_res_value;
  logic                           o_busy;
  logic                           o_overrun;

  // Environment side: produces updates, consumes results.
  modport master (
    output i_flush, i_clf_accum_reg, i_clf_accum_reg_vld,
    output i_rgs_accum_reg, i_rgs_accum_reg_vld, i_res_rdy,
    input  o_res_vld, o_res_is_clf, o_res_label, o_res_value,
    input  o_busy, o_overrun
  );

  // Block side.
  modport slave (
    input  i_flush, i_clf_accum_reg, i_clf_accum_reg_vld,
    input  i_rgs_accum_reg, i_rgs_accum_reg_vld, i_res_rdy,
    output o_res_vld, o_res_is_clf, o_res_label, o_res_value,
    output o_busy, o_overrun
  );

endinterface

// File: rtl/accum_argmax.sv
// Argmax over the classification sums, or pass-through of the regression sum.
// A clf update snapshots all label sums and scans them with one signed
// comparator, one label per cycle; ties keep the lower label. A rgs update
// goes straight to the output state. Updates arriving while busy are dropped
// and flagged on o_overrun.
module accum_argmax
  import accum_pkg::*;
#(
  parameter int N_LABELS   = ACC_N_LABELS,
  parameter int FIFO_WIDTH = ACC_FIFO_WIDTH,
  localparam int LBL_W     = $clog2(N_LABELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_flush,
  input  logic [N_LABELS*FIFO_WIDTH-1:0] i_clf_accum_reg,
  input  logic [N_LABELS-1:0]            i_clf_accum_reg_vld,
  input  logic [FIFO_WIDTH-1:0]          i_rgs_accum_reg,
  input  logic                           i_rgs_accum_reg_vld,
  output logic                           o_res_vld,
  input  logic                           i_res_rdy,
  output logic                           o_res_is_clf,
  output logic [LBL_W-1:0]               o_res_label,
  output logic [FIFO_WIDTH-1:0]          o_res_value,
  output logic                           o_busy,
  output logic                           o_overrun,
  output state_t                         o_state
);

  localparam logic [LBL_W-1:0] LAST_IDX = LBL_W'(N_LABELS - 1);

  state_t                         state_q, state_d;
  logic signed [FIFO_WIDTH-1:0]   vals_q [N_LABELS];
  logic signed [FIFO_WIDTH-1:0]   vals_d [N_LABELS];
  logic signed [FIFO_WIDTH-1:0]   best_q, best_d;
  logic [LBL_W-1:0]               best_idx_q, best_idx_d;
  logic [LBL_W-1:0]               idx_q, idx_d;
  logic                           is_clf_q, is_clf_d;
  logic                           overrun_q, overrun_d;

  logic                           clf_any;
  logic                           any_upd;
  logic signed [FIFO_WIDTH-1:0]   cand;
  logic                           cand_gt;

  assign clf_any = |i_clf_accum_reg_vld;
  assign any_upd = clf_any | i_rgs_accum_reg_vld;

  // The one comparator shared by every scan step; strict '>' keeps ties low.
  assign cand    = vals_q[idx_q];
  assign cand_gt = (cand > best_q);

  // Next-state, capture, scan and drop-detection logic.
  always_comb begin
    state_d    = state_q;
    vals_d     = vals_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    idx_d      = idx_q;
    is_clf_d   = is_clf_q;
    overrun_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clf_any) begin
          for (int k = 0; k < N_LABELS; k++) begin
            vals_d[k] = i_clf_accum_reg[k*FIFO_WIDTH +: FIFO_WIDTH];
          end
          best_d     = i_clf_accum_reg[FIFO_WIDTH-1:0];
          best_idx_d = '0;
          idx_d      = LBL_W'(1);
          is_clf_d   = 1'b1;
          state_d    = ST_SCAN;
          // A rgs pulse in the same cycle loses to clf.
          overrun_d  = i_rgs_accum_reg_vld;
        end else if (i_rgs_accum_reg_vld) begin
          best_d     = i_rgs_accum_reg;
          best_idx_d = '0;
          is_clf_d   = 1'b0;
          state_d    = ST_OUT;
        end
      end
      ST_SCAN: begin
        overrun_d = any_upd;
        if (cand_gt) begin
          best_d     = cand;
          best_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + LBL_W'(1);
        end
      end
      ST_OUT: begin
        // Updates are refused even on the handshake cycle itself.
        overrun_d = any_upd;
        if (i_res_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush wins over any capture and is never reported as an overrun.
    if (i_flush) begin
      state_d   = ST_IDLE;
      overrun_d = 1'b0;
    end
  end

  // State and datapath registers; reset clears everything the outputs show.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      for (int k = 0; k < N_LABELS; k++) begin
        vals_q[k] <= '0;
      end
      best_q     <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      is_clf_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vals_q     <= vals_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      idx_q      <= idx_d;
      is_clf_q   <= is_clf_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_res_vld    = (state_q == ST_OUT);
  assign o_res_is_clf = is_clf_q;
  assign o_res_label  = best_idx_q;
  assign o_res_value  = best_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_overrun    = overrun_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_accum_argmax.sv
// Directed bench for accum_argmax: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares on every result handshake.
module tb_accum_argmax;
  import accum_pkg::*;

  localparam int NL = 4;
  localparam int W  = 16;
  localparam int LW = 2;
  localparam int RW = 1 + LW + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accum_argmax_if #(.N_LABELS(NL), .FIFO_WIDTH(W)) bus ();
  state_t dbg_state;

  accum_argmax #(.N_LABELS(NL), .FIFO_WIDTH(W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_flush             (bus.i_flush),
    .i_clf_accum_reg     (bus.i_clf_accum_reg),
    .i_clf_accum_reg_vld (bus.i_clf_accum_reg_vld),
    .i_rgs_accum_reg     (bus.i_rgs_accum_reg),
    .i_rgs_accum_reg_vld (bus.i_rgs_accum_reg_vld),
    .o_res_vld           (bus.o_res_vld),
    .i_res_rdy           (bus.i_res_rdy),
    .o_res_is_clf        (bus.o_res_is_clf),
    .o_res_label         (bus.o_res_label),
    .o_res_value         (bus.o_res_value),
    .o_busy              (bus.o_busy),
    .o_overrun           (bus.o_overrun),
    .o_state             (dbg_state)
  );

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] cur_word;
  int pass_cnt  = 0;
  int total_cnt = 0;
  int hs_cnt    = 0;
  int ovr_cnt   = 0;

  assign cur_word = {bus.o_res_is_clf, bus.o_res_label, bus.o_res_value};

  function automatic logic [RW-1:0] mk(input logic c, input logic [LW-1:0] l,
                                       input logic [W-1:0] v);
    return {c, l, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_flush             = 1'b0;
    bus.i_clf_accum_reg     = '0;
    bus.i_clf_accum_reg_vld = '0;
    bus.i_rgs_accum_reg     = '0;
    bus.i_rgs_accum_reg_vld = 1'b0;
  endtask

  task automatic set_clf(input logic [W-1:0] v0, input logic [W-1:0] v1,
                         input logic [W-1:0] v2, input logic [W-1:0] v3,
                         input logic [NL-1:0] vld);
    bus.i_clf_accum_reg     = {v3, v2, v1, v0};
    bus.i_clf_accum_reg_vld = vld;
  endtask

  task automatic set_rgs(input logic [W-1:0] v);
    bus.i_rgs_accum_reg     = v;
    bus.i_rgs_accum_reg_vld = 1'b1;
  endtask

  // Clears the update pulses and counts cycles until o_res_vld (bounded).
  task automatic wait_res(input string name, input int exp_lat);
    int lat;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      bus.i_clf_accum_reg_vld = '0;
      bus.i_rgs_accum_reg_vld = 1'b0;
      @(negedge clk);
      if (bus.o_res_vld) begin
        lat = k;
        break;
      end
    end
    check(name, lat, exp_lat);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Pops one expected result per handshake; also tallies overrun pulses.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.o_overrun === 1'b1) ovr_cnt++;
      if (bus.o_res_vld === 1'b1 && bus.i_res_rdy === 1'b1) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_result: got %0h, expected no result", cur_word);
        end else begin
          check("result", 32'(cur_word), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ovr0;
    rst = 1'b1;
    idle_inputs();
    bus.i_res_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld",    bus.o_res_vld,    0);
    check("rst_is_clf", bus.o_res_is_clf, 0);
    check("rst_label",  bus.o_res_label,  0);
    check("rst_value",  bus.o_res_value,  0);
    check("rst_busy",   bus.o_busy,       0);
    check("rst_ovr",    bus.o_overrun,    0);
    check("rst_state",  dbg_state,        ST_IDLE);
    step();
    rst = 1'b0;

    // Argmax, clear winner in the middle.
    set_clf(16'sd10, -16'sd3, 16'sd25, 16'sd7, 4'b0001);
    exp_q.push_back(mk(1'b1, 2'd2, 16'sd25));
    wait_res("lat_clf_a", 4);

    // Negative values with a tie: lower index wins.
    step();
    set_clf(-16'sd5, -16'sd2, -16'sd2, -16'sd9, 4'b1000);
    exp_q.push_back(mk(1'b1, 2'd1, -16'sd2));
    wait_res("lat_clf_tie", 4);

    // Regression held by back-pressure.
    step();
    bus.i_res_rdy = 1'b0;
    set_rgs(16'h8001);
    exp_q.push_back(mk(1'b0, 2'd0, 16'h8001));
    wait_res("lat_rgs", 1);
    check("rgs_hold", 32'(cur_word), 32'(mk(1'b0, 2'd0, 16'h8001)));
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      check("rgs_hold", 32'(cur_word), 32'(mk(1'b0, 2'd0, 16'h8001)));
    end
    step();
    bus.i_res_rdy = 1'b1;
    step();
    @(negedge clk);
    check("rgs_vld_drop", bus.o_res_vld, 0);

    // clf+rgs collision, then a second clf during SCAN.
    step();
    ovr0 = ovr_cnt;
    set_clf(16'sd1, 16'sd2, 16'sd3, 16'sd4, 4'b0110);
    set_rgs(16'sd5);
    exp_q.push_back(mk(1'b1, 2'd3, 16'sd4));
    step();
    bus.i_rgs_accum_reg_vld = 1'b0;
    set_clf(16'sd100, 16'sd100, 16'sd100, 16'sd100, 4'b1111);
    @(negedge clk);
    check("ovr_collide", bus.o_overrun, 1);
    wait_res("lat_collide", 3);
    check("ovr_collide_cnt", ovr_cnt - ovr0, 2);

    // Flush in IDLE beats a capture and does not flag overrun.
    step();
    bus.i_flush = 1'b1;
    set_clf(16'sd9, 16'sd9, 16'sd9, 16'sd9, 4'b0001);
    step();
    bus.i_flush = 1'b0;
    bus.i_clf_accum_reg_vld = '0;
    @(negedge clk);
    check("flush_idle_busy", bus.o_busy, 0);
    check("flush_idle_ovr",  bus.o_overrun, 0);

    // Flush during SCAN cycle 2, then a fresh result with max at last label.
    step();
    set_clf(16'sd5, 16'sd6, 16'sd7, 16'sd8, 4'b0001);
    step();
    bus.i_clf_accum_reg_vld = '0;
    step();
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    @(negedge clk);
    check("flush_scan_busy",  bus.o_busy,    0);
    check("flush_scan_vld",   bus.o_res_vld, 0);
    check("flush_scan_ovr",   bus.o_overrun, 0);
    check("flush_scan_state", dbg_state,     ST_IDLE);
    step();
    set_clf(-16'sd1, -16'sd1, -16'sd1, 16'sd5, 4'b0100);
    exp_q.push_back(mk(1'b1, 2'd3, 16'sd5));
    wait_res("lat_after_flush", 4);

    // Update on the OUT handshake cycle is dropped.
    step();
    bus.i_res_rdy = 1'b0;
    set_rgs(16'h00AA);
    exp_q.push_back(mk(1'b0, 2'd0, 16'h00AA));
    wait_res("lat_rgs_hs", 1);
    step();
    bus.i_res_rdy = 1'b1;
    set_clf(16'sd1, 16'sd1, 16'sd1, 16'sd1, 4'b0010);
    step();
    bus.i_clf_accum_reg_vld = '0;
    @(negedge clk);
    check("hs_drop_vld",  bus.o_res_vld, 0);
    check("hs_drop_busy", bus.o_busy,    0);
    check("hs_drop_ovr",  bus.o_overrun, 1);

    // Reset while in OUT discards the result.
    step();
    bus.i_res_rdy = 1'b0;
    set_rgs(16'h1234);
    wait_res("lat_rgs_rst", 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_vld",    bus.o_res_vld,    0);
    check("rst_out_is_clf", bus.o_res_is_clf, 0);
    check("rst_out_label",  bus.o_res_label,  0);
    check("rst_out_value",  bus.o_res_value,  0);
    check("rst_out_busy",   bus.o_busy,       0);
    check("rst_out_ovr",    bus.o_overrun,    0);
    step();
    bus.i_res_rdy = 1'b1;
    repeat (3) step();
    @(negedge clk);

    // ---------------- final report ----------------
    check("queue_empty", exp_q.size(), 0);
    check("handshakes",  hs_cnt, 6);
    check("overruns",    ovr_cnt, 3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/accum_argmax.md
ACCUM_ARGMAX -- requirements
Module: accum_argmax

Interface
REQ-001 The block SHALL have parameter N_LABELS, default 4, giving the number of classification registers consumed (N_LABELS >= 2).
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 16, giving the width of each accumulated value, interpreted as signed two's complement.
REQ-003 The block SHALL have derived localparam LBL_W = $clog2(N_LABELS).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port i_flush, input, 1 bit: abort the current operation and return to IDLE.
REQ-007 The block SHALL have port i_clf_accum_reg, input, N_LABELS*FIFO_WIDTH bits: classification sums, label k at bits [k*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 The block SHALL have port i_clf_accum_reg_vld, input, N_LABELS bits: per-label update pulse from the upstream accumulator.
REQ-009 The block SHALL have port i_rgs_accum_reg, input, FIFO_WIDTH bits: regression sum.
REQ-010 The block SHALL have port i_rgs_accum_reg_vld, input, 1 bit: regression update pulse.
REQ-011 The block SHALL have port o_res_vld, input-side handshake output, 1 bit: result valid.
REQ-012 The block SHALL have port i_res_rdy, input, 1 bit: consumer ready.
REQ-013 The block SHALL have port o_res_is_clf, output, 1 bit: 1 for a classification result, 0 for regression.
REQ-014 The block SHALL have port o_res_label, output, LBL_W bits: winning label (0 for regression).
REQ-015 The block SHALL have port o_res_value, output, FIFO_WIDTH bits: winning sum or regression value.
REQ-016 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 The block SHALL have port o_overrun, output, 1 bit: single-cycle pulse when an input update is dropped.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, SCAN, OUT.
REQ-019 In IDLE, when any bit of i_clf_accum_reg_vld is high, the block SHALL snapshot all N_LABELS values, set is_clf=1, set best=value[0], set best_idx=0, set idx=1, and go to SCAN.
REQ-020 In IDLE, when i_rgs_accum_reg_vld=1 and no clf valid bit is high, the block SHALL latch i_rgs_accum_reg, set is_clf=0, set label=0, and go to OUT.
REQ-021 When clf and rgs valids arrive in the same cycle in IDLE, clf SHALL win, rgs SHALL be dropped, and o_overrun SHALL pulse in the next cycle.
REQ-022 In SCAN, the block SHALL perform one signed compare per cycle: if value[idx] > best, then best and best_idx update; ties SHALL keep the lower index.
REQ-023 SCAN SHALL exit to OUT after idx = N_LABELS-1 is compared; clf latency SHALL be N_LABELS cycles from the valid cycle to o_res_vld high, and rgs latency SHALL be 1 cycle.
REQ-024 In OUT, o_res_vld SHALL be 1 and the outputs SHALL stay stable until i_res_rdy=1; on that handshake cycle the block SHALL return to IDLE, and o_res_vld SHALL be 0 in the next cycle.
REQ-025 Any clf or rgs valid arriving while the state is not IDLE (including the OUT handshake cycle) SHALL be dropped and SHALL pulse o_overrun one cycle later.
REQ-026 i_flush SHALL force IDLE and clear o_res_vld in the next cycle, SHALL take priority over any capture in the same cycle, and SHALL NOT assert o_overrun.
REQ-027 o_res_label, o_res_value, and o_res_is_clf SHALL be registered and SHALL be valid only while o_res_vld=1.

Reset
REQ-028 On rst=1 at a clock edge, the state SHALL be IDLE and o_res_vld, o_res_is_clf, o_res_label, o_res_value, o_busy, and o_overrun SHALL all be 0; rst SHALL dominate i_flush and all inputs.
REQ-029 Reset asserted in SCAN or OUT SHALL discard the in-flight result without any output pulse.

Structure
REQ-030 A shared package (accum_pkg) SHALL hold the FSM state enum and the default FIFO_WIDTH/N_LABELS constants reused by the accumulator and this block.
REQ-031 The block SHALL be a single module with no sub-modules; the compare SHALL be a single FIFO_WIDTH-bit signed comparator reused across SCAN cycles.

Verification
REQ-032 With N_LABELS=4, clf inputs {10,-3,25,7} valid at cycle 0, and rdy=1: o_res_vld SHALL rise at cycle 4 with label=2, value=25, is_clf=1.
REQ-033 Tie and negative values: inputs {-5,-2,-2,-9} SHALL produce label=1, value=-2.
REQ-034 Rgs valid with value 0x8001 and rdy held 0 for 5 cycles: o_res_vld SHALL be high from cycle 1, the outputs SHALL stay stable, and o_res_vld SHALL drop the cycle after rdy=1.
REQ-035 Simultaneous clf and rgs valid: the clf result SHALL be produced and o_overrun SHALL pulse once; a second clf valid during SCAN SHALL also pulse o_overrun and SHALL NOT alter the result.
REQ-036 i_flush during SCAN cycle 2 SHALL make the state IDLE with o_res_vld=0; a new clf valid afterwards SHALL produce a correct result.
REQ-037 rst asserted while in OUT SHALL clear all outputs to 0 in the next cycle, and no handshake SHALL occur.
